pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the single-cycle datapath: owns the PC register and resolves the next-PC choice among sequential fetch, taken branch and jump. Drives `branch_next`, the select line of the branch-target/ALU-path mux, and sequences fetch through a boot / run / halt / fault state machine. Sits between the control decoder and ALU zero flag on one side and instruction memory on the other.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word aligned.
- `PC_W`, 32: PC and target width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `branch`  in  1  decoded conditional-branch instruction.
- `zero`  in  1  ALU zero flag.
- `jump`  in  1  decoded unconditional jump.
- `branch_target`  in  PC_W  branch adder result.
- `jump_target`  in  PC_W  jump address.
- `stall`  in  1  hold PC this cycle.
- `halt`  in  1  current instruction is HALT.
- `resume`  in  1  leave HALT.
- `pc`  out  PC_W  current fetch address (registered).
- `pc_plus4`  out  PC_W  `pc + 4`, combinational.
- `branch_next`  out  1  mux select: 1 = branch target, 0 = sequential path.
- `pc_valid`  out  1  fetch at `pc` is live.
- `fault`  out  1  misaligned redirect detected (sticky).
- `fault_addr`  out  PC_W  offending target.
- `branch_count`  out  32  taken-branch count (only with `PC_SEQ_BRCNT_EN`).

## Operation
- States: BOOT, RUN, HALT, FAULT.
- BOOT: one cycle after reset release; `pc_valid`=0; next state RUN, PC unchanged.
- RUN: `pc_valid`=1. `branch_next = branch & zero & (state==RUN)`. Next PC priority: `jump` → `jump_target`; else `branch_next` → `branch_target`; else `pc_plus4`.
- Misalignment: selected redirect target with bits [1:0] ≠ 0 → FAULT; PC holds; `fault_addr` latches target; `fault`=1.
- `stall`=1 in RUN: PC holds, no state change; `halt`, redirects and fault checks ignored that cycle.
- `halt`=1 in RUN (no stall): PC holds, next state HALT. `jump`/`branch` asserted in the same cycle are ignored.
- HALT: `pc_valid`=0, `branch_next`=0; `resume`=1 → RUN with PC := `pc_plus4`.
- FAULT: `pc_valid`=0, `branch_next`=0; exit only by `rst`.
- Arithmetic: `pc_plus4` wraps modulo 2^PC_W (32'hFFFF_FFFC → 0); no fault on wrap.

## Timing
- Reset values: `pc`=RESET_PC, state BOOT, `pc_valid`=0, `branch_next`=0, `fault`=0, `fault_addr`=0, `branch_count`=0.
- `branch_next`, `pc_plus4`: combinational, same cycle as inputs.
- PC redirect latency: 1 edge; target visible on `pc` the cycle after `branch`/`jump` is sampled.
- Reset mid-operation: immediate async return to reset values regardless of state.
- `halt` and `resume` are level-sampled; `resume` outside HALT has no effect.

## Configuration
- `PC_SEQ_BRCNT_EN` defined: `branch_count` port present; increments on each edge in RUN with `stall`=0 and `branch_next`=1; saturates at 32'hFFFF_FFFF; cleared by `rst`.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `pc_seq_pkg`: state enum (BOOT, RUN, HALT, FAULT), `INSTR_BYTES`=4, default `RESET_PC`.
- Sub-module `next_pc_sel`: combinational priority select (jump/branch/sequential) plus alignment check; FSM, PC register and counter stay in top.

## Test plan
- Reset release, no controls → cycle 1 `pc`=0 `pc_valid`=0; cycles 2..4 `pc`=0,4,8.
- At pc=8, `branch`=1 `zero`=1 `branch_target`=0x40 → `branch_next`=1 same cycle, next `pc`=0x40; `zero`=0 → `pc`=0xC.
- `jump`=1 (target 0x100) and taken branch (target 0x40) together → `pc`=0x100.
- `stall`=1 three cycles with `halt`=1 → `pc` holds, state stays RUN; then `halt` alone → HALT, `pc_valid`=0; `resume` → `pc` advances by 4.
- `jump_target`=0x102 → `fault`=1, `fault_addr`=0x102, `pc` frozen; `rst` pulse mid-fault → all outputs back to reset values.
- With `PC_SEQ_BRCNT_EN`: five taken branches, one during stall → `branch_count`=4.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// instruction size in bytes and the default boot address.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC priority select (jump > taken branch > sequential)
// with a word-alignment check on whichever redirect target wins.
module next_pc_sel #(
  parameter int PC_W = 32
) (
  input  logic            jump,
  input  logic            branch_take,
  input  logic [PC_W-1:0] pc_plus4,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] next_pc,
  output logic            redirect,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_take) begin
      next_pc = branch_target;
    end
  end

  assign redirect = jump | branch_take;
  // Sequential fetch is aligned by construction, so only redirects are checked.
  assign misaligned = redirect & (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register plus BOOT/RUN/HALT/FAULT fetch FSM.
// Optional taken-branch counter enabled by defining PC_SEQ_BRCNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  input  logic            stall,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            branch_next,
  output logic            pc_valid,
  output logic            fault,
  output logic [PC_W-1:0] fault_addr
`ifdef PC_SEQ_BRCNT_EN
  ,
  output logic [31:0]     branch_count
`endif
);

  seq_state_t      state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] fault_addr_reg;
  logic            fault_reg;
  logic [PC_W-1:0] sel_pc;
  logic            sel_redirect;
  logic            sel_misaligned;
  logic            run_active;

  assign pc_plus4 = pc_reg + PC_W'(INSTR_BYTES);
  // A RUN cycle that actually commits a fetch decision (not stalled, not halting).
  assign run_active = (state_reg == RUN) && !stall && !halt;

  next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
    .jump          (jump),
    .branch_take   (branch_next),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .next_pc       (sel_pc),
    .redirect      (sel_redirect),
    .misaligned    (sel_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= BOOT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:  state_next = RUN;
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_next = HALT;
          end else if (sel_misaligned) begin
            state_next = FAULT;
          end
        end
      end
      HALT:  if (resume) state_next = RUN;
      FAULT: state_next = FAULT;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_valid    = (state_reg == RUN);
    branch_next = branch & zero & (state_reg == RUN);
  end

  always_comb begin
    pc_next = pc_reg;
    if (run_active && !sel_misaligned) begin
      pc_next = sel_pc;
    end else if (state_reg == HALT && resume) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg         <= RESET_PC;
      fault_reg      <= 1'b0;
      fault_addr_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (run_active && sel_misaligned) begin
        fault_reg      <= 1'b1;
        fault_addr_reg <= sel_pc;
      end
    end
  end

  assign pc         = pc_reg;
  assign fault      = fault_reg;
  assign fault_addr = fault_addr_reg;

`ifdef PC_SEQ_BRCNT_EN
  logic [31:0] br_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt_reg <= '0;
    end else if ((state_reg == RUN) && !stall && branch_next && (br_cnt_reg != 32'hFFFF_FFFF)) begin
      br_cnt_reg <= br_cnt_reg + 32'd1;
    end
  end

  assign branch_count = br_cnt_reg;
`endif

  // sel_redirect is informational for the select block; keep it observed.
  logic unused_ok;
  assign unused_ok = sel_redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; expected PCs go through a scoreboard
// queue when stimulus is driven and are popped after the clock edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch, zero, jump, stall, halt, resume;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4, fault_addr;
  logic        branch_next, pc_valid, fault;
`ifdef PC_SEQ_BRCNT_EN
  logic [31:0] branch_count;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .branch        (branch),
    .zero          (zero),
    .jump          (jump),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt          (halt),
    .resume        (resume),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_next   (branch_next),
    .pc_valid      (pc_valid),
    .fault         (fault),
    .fault_addr    (fault_addr)
`ifdef PC_SEQ_BRCNT_EN
    ,
    .branch_count  (branch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch = 0; zero = 0; jump = 0; stall = 0; halt = 0; resume = 0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pc_valid); end
    checks++; if (fault !== 1'b0 || fault_addr !== 32'h0) begin errors++; $display("FAIL reset_fault got=%b/%h exp=0/0", fault, fault_addr); end
    checks++; if (branch_next !== 1'b0) begin errors++; $display("FAIL reset_branch_next got=%b exp=0", branch_next); end
    rst = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL boot got pc=%h valid=%b exp pc=0 valid=0", pc, pc_valid); end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      e = exp_q.pop_front();
      $display("txn seq pc=%h exp=%h valid=%b", pc, e, pc_valid);
      checks++; if (pc !== e || pc_valid !== 1'b1) begin errors++; $display("FAIL seq_pc got=%h/%b exp=%h/1", pc, pc_valid, e); end
    end
  endtask

  task automatic test_branch();
    // not-taken at pc=8, then taken at pc=0xC
    branch = 1; zero = 0; branch_target = 32'h40;
    #1;
    checks++; if (branch_next !== 1'b0 || pc_plus4 !== 32'hC) begin errors++; $display("FAIL branch_nt_comb got=%b/%h exp=0/0000000c", branch_next, pc_plus4); end
    exp_q.push_back(32'hC);
    tick();
    e = exp_q.pop_front();
    $display("txn branch_nt pc=%h exp=%h", pc, e);
    checks++; if (pc !== e) begin errors++; $display("FAIL branch_nt got=%h exp=%h", pc, e); end
    zero = 1;
    #1;
    checks++; if (branch_next !== 1'b1) begin errors++; $display("FAIL branch_next_comb got=%b exp=1", branch_next); end
    exp_q.push_back(32'h40);
    tick();
    e = exp_q.pop_front();
    $display("txn branch_taken pc=%h exp=%h", pc, e);
    checks++; if (pc !== e) begin errors++; $display("FAIL branch_taken got=%h exp=%h", pc, e); end
    clear_inputs();
  endtask

  task automatic test_jump_priority();
    jump = 1; jump_target = 32'h100; branch = 1; zero = 1; branch_target = 32'h40;
    exp_q.push_back(32'h100);
    tick();
    e = exp_q.pop_front();
    $display("txn jump_prio pc=%h exp=%h", pc, e);
    checks++; if (pc !== e) begin errors++; $display("FAIL jump_priority got=%h exp=%h", pc, e); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      jump = 1; jump_target = 32'h200 + 32'(i * 16);
      exp_q.push_back(jump_target);
      tick();
      e = exp_q.pop_front();
      $display("txn b2b_jump pc=%h exp=%h", pc, e);
      checks++; if (pc !== e) begin errors++; $display("FAIL b2b_jump got=%h exp=%h", pc, e); end
    end
    jump = 1; jump_target = 32'h100;
    tick();
    clear_inputs();
  endtask

  task automatic test_stall_halt();
    // stall masks halt and a misaligned jump
    stall = 1; halt = 1; jump = 1; jump_target = 32'h102;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h100);
      tick();
      e = exp_q.pop_front();
      $display("txn stall pc=%h exp=%h valid=%b fault=%b", pc, e, pc_valid, fault);
      checks++; if (pc !== e || pc_valid !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL stall got=%h/%b/%b exp=%h/1/0", pc, pc_valid, fault, e); end
    end
    stall = 0; jump_target = 32'h300;
    exp_q.push_back(32'h100);
    tick();
    e = exp_q.pop_front();
    $display("txn halt pc=%h exp=%h valid=%b", pc, e, pc_valid);
    checks++; if (pc !== e || pc_valid !== 1'b0) begin errors++; $display("FAIL halt got=%h/%b exp=%h/0", pc, pc_valid, e); end
    halt = 0; jump = 0; branch = 1; zero = 1; branch_target = 32'h40;
    #1;
    checks++; if (branch_next !== 1'b0) begin errors++; $display("FAIL halt_branch_next got=%b exp=0", branch_next); end
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL halt_hold got=%h exp=00000100", pc); end
    clear_inputs();
    resume = 1;
    exp_q.push_back(32'h104);
    tick();
    e = exp_q.pop_front();
    $display("txn resume pc=%h exp=%h valid=%b", pc, e, pc_valid);
    checks++; if (pc !== e || pc_valid !== 1'b1) begin errors++; $display("FAIL resume got=%h/%b exp=%h/1", pc, pc_valid, e); end
    // resume outside HALT is a no-op: sequential advance
    exp_q.push_back(32'h108);
    tick();
    e = exp_q.pop_front();
    checks++; if (pc !== e) begin errors++; $display("FAIL resume_in_run got=%h exp=%h", pc, e); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick();
    clear_inputs();
    #1;
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front();
    $display("txn wrap pc=%h exp=%h fault=%b", pc, e, fault);
    checks++; if (pc !== e || fault !== 1'b0 || pc_valid !== 1'b1) begin errors++; $display("FAIL wrap got=%h/%b exp=%h/0", pc, fault, e); end
  endtask

  task automatic test_fault();
    jump = 1; jump_target = 32'h300;
    tick();
    jump_target = 32'h102;
    exp_q.push_back(32'h300);
    tick();
    e = exp_q.pop_front();
    $display("txn fault pc=%h exp=%h fault=%b addr=%h", pc, e, fault, fault_addr);
    checks++; if (pc !== e) begin errors++; $display("FAIL fault_pc got=%h exp=%h", pc, e); end
    checks++; if (fault !== 1'b1 || fault_addr !== 32'h102 || pc_valid !== 1'b0) begin errors++; $display("FAIL fault_flags got=%b/%h/%b exp=1/00000102/0", fault, fault_addr, pc_valid); end
    jump = 0; branch = 1; zero = 1; branch_target = 32'h40; resume = 1;
    #1;
    checks++; if (branch_next !== 1'b0) begin errors++; $display("FAIL fault_branch_next got=%b exp=0", branch_next); end
    tick();
    checks++; if (pc !== 32'h300 || fault !== 1'b1 || pc_valid !== 1'b0) begin errors++; $display("FAIL fault_sticky got=%h/%b/%b exp=00000300/1/0", pc, fault, pc_valid); end
    clear_inputs();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (pc !== 32'h0 || fault !== 1'b0 || fault_addr !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%b/%h/%b exp=0/0/0/0", pc, fault, fault_addr, pc_valid); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL post_reset_run got=%h/%b exp=0/1", pc, pc_valid); end
  endtask

`ifdef PC_SEQ_BRCNT_EN
  task automatic test_brcnt();
    rst = 1'b1;
    clear_inputs();
    tick();
    checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL brcnt_reset got=%0d exp=0", branch_count); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      branch = 1; zero = 1; branch_target = 32'h40 * 32'(i + 1);
      stall = (i == 2);
      tick();
    end
    clear_inputs();
    $display("txn brcnt count=%0d exp=4", branch_count);
    checks++; if (branch_count !== 32'd4) begin errors++; $display("FAIL brcnt got=%0d exp=4", branch_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_jump_priority();
    test_back_to_back();
    test_stall_halt();
    test_wrap();
    test_fault();
`ifdef PC_SEQ_BRCNT_EN
    test_brcnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
